ps2_frame_receiver: RTL and testbench
=====================================

Name: ps2_frame_receiver

Overview:
- Receive-only PS/2 device-to-host link layer feeding the keyboard scan-code handler. It provides that handler's received_data / received_data_en byte stream.
- Synchronises the PS2_CLK and PS2_DAT lines, deframes each 11-bit frame (start, 8 data LSB-first, odd parity, stop) and emits one-cycle byte strobes.
- Reports parity, framing and timeout errors.
- Line tristate and the host-to-device command path live in the pad wrapper, not here.

Parameters:
- TIMEOUT_CYCLES, 100000, CLOCK_50 cycles allowed between consecutive PS2_CLK falling edges inside a frame (2 ms at 50 MHz).
- FILTER_LEN, 8, consecutive equal samples required by the optional glitch filter.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2_clk_in  in  1  raw PS2_CLK pad input
- ps2_dat_in  in  1  raw PS2_DAT pad input
- received_data  out  8  last correctly received byte
- received_data_en  out  1  one-cycle strobe; received_data is valid in the same cycle
- parity_error  out  1  one-cycle strobe on a parity mismatch
- framing_error  out  1  one-cycle strobe on a bad stop bit or an intra-frame timeout
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Clock and reset: single domain, CLOCK_50. Reset is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, shift register 0, bit counter 0, timeout counter 0, synchroniser flops 1 (idle bus level).
- Reset mid-frame aborts the frame immediately. No strobe is produced for the aborted frame.
- Synchroniser: both lines pass through 2-flop synchronisers.
- Falling edge: fall = prev_clk_s & ~clk_s, evaluated on synchronised values. The data bit is sampled from synchronised dat in the same cycle as fall.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on fall with dat=0, go to DATA and clear the bit counter. On fall with dat=1 (bogus start), stay in IDLE with no error.
- DATA: on each fall, shift the bit in LSB-first (shift right, new bit to [7]). After the 8th bit (counter 7), go to PARITY.
- PARITY: on fall, latch the parity bit and go to STOP.
- STOP, on fall:
  - dat=1 and ^{data,parity}=1: load received_data and pulse received_data_en.
  - dat=1 and parity wrong: pulse parity_error only; received_data is unchanged.
  - dat=0: pulse framing_error only. Framing takes precedence over parity.
  - Always return to IDLE.
- Latency: strobes are registered and assert in the cycle after the stop-bit fall is detected. That is 3 cycles after the raw pad edge (2 synchroniser stages plus 1 output register).
- received_data holds its value until the next good frame.
- Timeout: the counter clears on every fall and increments every cycle while state != IDLE.
  - When it reaches TIMEOUT_CYCLES-1: pulse framing_error, go to IDLE, clear the shift register.
  - A fall in the same cycle as the timeout wins: the frame continues and the counter clears.
  - The counter width is $clog2(TIMEOUT_CYCLES) and saturates; it never wraps.
- Back-to-back frames: the first start bit after STOP is accepted with no idle gap required.
- At most one of the three strobes is asserted in any cycle.

Optional Feature:
- Macro: PS2_RX_GLITCH_FILTER_EN.
- When defined: each synchronised line feeds a FILTER_LEN-sample majority-free debounce. The filtered output changes only after FILTER_LEN consecutive identical samples, which adds FILTER_LEN cycles of latency to both lines equally.
- When undefined: the filtered outputs equal the synchroniser outputs, FILTER_LEN is unused, and the logic is identical to the unfiltered path.

Decomposition:
- Package ps2_pkg holds:
  - the state enum {IDLE, DATA, PARITY, STOP};
  - the constants PS2_DATA_BITS=8 and PS2_FRAME_BITS=11;
  - a function odd_parity_ok(data, parity).
- One sub-module, ps2_line_conditioner, instantiated once per line. It contains the 2-flop synchroniser plus the optional filter and outputs a clean level. Edge detection stays in the top level.

Test Plan:
- Make code: frame for 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1 including start, parity=0, stop=1) at 12.5 kHz -> one received_data_en pulse with received_data=0x1C, no error strobes; busy is low afterwards.
- Break sequence: frames 0xF0 (parity 1) then 0x1C sent back-to-back -> two strobes in order, 0xF0 then 0x1C; received_data is 0x1C at the end.
- Bad parity: 0xE0 sent with parity=1 -> parity_error pulse, no received_data_en, received_data keeps its previous value 0x1C.
- Bad stop: 0x00 (parity 1) with stop=0 -> framing_error only, even if the parity bit is also corrupted.
- Timeout: clock stopped after 4 data bits for TIMEOUT_CYCLES cycles -> framing_error exactly at count TIMEOUT_CYCLES-1, busy drops. A following valid 0x29 frame is received correctly.
- Reset and glitches: assert reset mid-DATA -> outputs 0 asynchronously, no strobe, and the next frame is decoded. With PS2_RX_GLITCH_FILTER_EN defined, 3-cycle low glitches on PS2_CLK between bits are ignored and the byte 0x5A is still received.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, frame constants and parity helper for the PS/2 receiver
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

   localparam int PS2_DATA_BITS  = 8;
   localparam int PS2_FRAME_BITS = 11;

   function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_line_conditioner.sv
// ps2_line_conditioner: 2-flop synchroniser plus optional debounce (PS2_RX_GLITCH_FILTER_EN) for one PS/2 line
module ps2_line_conditioner #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic line_out
);

   logic [1:0] sync_q, sync_d;

   if (FILTER_LEN < 1) begin : g_filter_len_invalid
      $error("FILTER_LEN must be at least 1");
   end

   // shift the raw pad level through two metastability flops
   always_comb sync_d = {sync_q[0], line_in};

   // synchroniser flops idle at the released-bus level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= sync_d;
   end

`ifdef PS2_RX_GLITCH_FILTER_EN
   localparam int FW = $clog2(FILTER_LEN) + 1;

   logic [FW-1:0] cnt_q, cnt_d;
   logic          filt_q, filt_d;

   // count consecutive samples that disagree with the current output; flip after FILTER_LEN of them
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q[1] != filt_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = sync_q[1];
            cnt_d  = '0;
         end
      end
   end

   // filter state also idles high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         filt_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign line_out = filt_q;
`else
   assign line_out = sync_q[1];
`endif

endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: PS/2 device-to-host deframer with byte strobe and error strobes; optional line filter via PS2_RX_GLITCH_FILTER_EN
module ps2_frame_receiver
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic [7:0] received_data,
   output logic       received_data_en,
   output logic       parity_error,
   output logic       framing_error,
   output logic       busy
);

   localparam int             CW     = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]  TO_MAX = CW'(TIMEOUT_CYCLES - 1);

   logic                     clk_s, dat_s, fall;
   logic                     prev_clk_q, prev_clk_d;
   ps2_state_e               state_q, state_d;
   logic [PS2_DATA_BITS-1:0] sr_q, sr_d, data_q, data_d;
   logic [2:0]               bit_cnt_q, bit_cnt_d;
   logic                     par_q, par_d;
   logic [CW-1:0]            to_cnt_q, to_cnt_d;
   logic                     data_en_q, data_en_d, par_err_q, par_err_d, frm_err_q, frm_err_d;

   ps2_line_conditioner #(.FILTER_LEN(FILTER_LEN)) u_clk (
      .clk(CLOCK_50), .rst(reset), .line_in(ps2_clk_in), .line_out(clk_s)
   );

   ps2_line_conditioner #(.FILTER_LEN(FILTER_LEN)) u_dat (
      .clk(CLOCK_50), .rst(reset), .line_in(ps2_dat_in), .line_out(dat_s)
   );

   // deframe on each PS2_CLK falling edge; the intra-frame timeout loses to a simultaneous edge
   always_comb begin
      fall       = prev_clk_q & ~clk_s;
      prev_clk_d = clk_s;
      state_d    = state_q;
      sr_d       = sr_q;
      bit_cnt_d  = bit_cnt_q;
      par_d      = par_q;
      data_d     = data_q;
      data_en_d  = 1'b0;
      par_err_d  = 1'b0;
      frm_err_d  = 1'b0;
      to_cnt_d   = (fall || state_q == IDLE) ? '0 : (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
      if (state_q != IDLE && !fall && to_cnt_q == TO_MAX) begin
         state_d   = IDLE;
         sr_d      = '0;
         frm_err_d = 1'b1;
         to_cnt_d  = '0;
      end else if (fall) begin
         case (state_q)
            IDLE: begin
               state_d   = dat_s ? IDLE : DATA;
               bit_cnt_d = '0;
            end
            DATA: begin
               sr_d      = {dat_s, sr_q[PS2_DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
               par_d   = dat_s;
               state_d = STOP;
            end
            default: begin
               state_d   = IDLE;
               frm_err_d = ~dat_s;
               data_en_d = dat_s & odd_parity_ok(sr_q, par_q);
               par_err_d = dat_s & ~odd_parity_ok(sr_q, par_q);
               data_d    = data_en_d ? sr_q : data_q;
            end
         endcase
      end
   end

   // register state, datapath and all strobes
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         prev_clk_q <= 1'b1;
         state_q    <= IDLE;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         par_q      <= 1'b0;
         to_cnt_q   <= '0;
         data_q     <= '0;
         data_en_q  <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         prev_clk_q <= prev_clk_d;
         state_q    <= state_d;
         sr_q       <= sr_d;
         bit_cnt_q  <= bit_cnt_d;
         par_q      <= par_d;
         to_cnt_q   <= to_cnt_d;
         data_q     <= data_d;
         data_en_q  <= data_en_d;
         par_err_q  <= par_err_d;
         frm_err_q  <= frm_err_d;
      end
   end

   assign received_data    = data_q;
   assign received_data_en = data_en_q;
   assign parity_error     = par_err_q;
   assign framing_error    = frm_err_q;
   assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb_ps2_frame_receiver: randomized self-checking bench against a frame-level reference model
module tb_ps2_frame_receiver;

   localparam int T  = 300;
   localparam int F  = 8;
   localparam int H  = 20;
`ifdef PS2_RX_GLITCH_FILTER_EN
   localparam int FL = F;
`else
   localparam int FL = 0;
`endif

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk_in = 1'b1;
   logic       ps2_dat_in = 1'b1;
   logic [7:0] received_data;
   logic       received_data_en, parity_error, framing_error, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int multi = 0;
   int got[$];
   int exp_q[$];
   int last_good = 0;

   ps2_frame_receiver #(.TIMEOUT_CYCLES(T), .FILTER_LEN(F)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
      .received_data(received_data), .received_data_en(received_data_en),
      .parity_error(parity_error), .framing_error(framing_error), .busy(busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // event log: byte value for a good frame, 256 for parity error, 512 for framing error
   always @(negedge CLOCK_50) begin
      if (received_data_en) got.push_back(int'(received_data));
      if (parity_error) got.push_back(256);
      if (framing_error) got.push_back(512);
      if (int'(received_data_en) + int'(parity_error) + int'(framing_error) > 1) multi++;
   end

   // reference: what a frame should produce, straight from the PS/2 frame rules
   function automatic int model(input logic [7:0] d, input logic p, input logic s);
      if (!s) return 512;
      if ((($countones(d) + int'(p)) % 2) == 1) return int'(d);
      return 256;
   endfunction

   function automatic logic good_par(input logic [7:0] d);
      return ~^d;
   endfunction

   task automatic send_bit(input logic b, input bit glitch);
      ps2_dat_in = b;
      if (glitch) begin
         repeat (6) @(negedge CLOCK_50);
         ps2_clk_in = 1'b0;
         repeat (3) @(negedge CLOCK_50);
         ps2_clk_in = 1'b1;
         repeat (H - 9) @(negedge CLOCK_50);
      end else repeat (H) @(negedge CLOCK_50);
      ps2_clk_in = 1'b0;
      repeat (H) @(negedge CLOCK_50);
      ps2_clk_in = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit glitch);
      send_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
      send_bit(p, glitch);
      send_bit(s, glitch);
      ps2_dat_in = 1'b1;
      exp_q.push_back(model(d, p, s));
      if (model(d, p, s) < 256) last_good = int'(d);
   endtask

   task automatic settle();
      repeat (3 * H) @(negedge CLOCK_50);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge CLOCK_50);
      n_cmp++;
      if ({received_data, received_data_en, parity_error, framing_error, busy} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h expected 000", {received_data, received_data_en, parity_error, framing_error, busy});
      end
      reset = 1'b0;
      repeat (5) @(negedge CLOCK_50);
      n_cmp++;
      if ({received_data, received_data_en, parity_error, framing_error, busy} !== 12'h000) begin
         n_bad++;
         $display("FAIL post_reset_idle: got %h expected 000", {received_data, received_data_en, parity_error, framing_error, busy});
      end
   endtask

   task automatic test_make_code();
      got.delete(); exp_q.delete();
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      settle();
      n_cmp++;
      if (got.size() != 1 || got[0] !== exp_q[0]) begin
         n_bad++;
         $display("FAIL make_code: got %0d events first %0d expected 1 event %0d", got.size(), got.size() ? got[0] : -1, exp_q[0]);
      end
      n_cmp++;
      if (busy !== 1'b0 || received_data !== 8'h1C) begin
         n_bad++;
         $display("FAIL make_code_state: busy %b data %h expected busy 0 data 1c", busy, received_data);
      end
   endtask

   task automatic test_back_to_back();
      got.delete(); exp_q.delete();
      send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      settle();
      n_cmp++;
      if (got.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL break_count: got %0d events expected %0d", got.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         n_cmp++;
         if (got[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL break_event%0d: got %0d expected %0d", i, got[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (received_data !== 8'h1C) begin
         n_bad++;
         $display("FAIL break_final: got %h expected 1c", received_data);
      end
   endtask

   task automatic test_errors();
      got.delete(); exp_q.delete();
      send_frame(8'hE0, 1'b1, 1'b1, 1'b0);
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(8'h00, 1'b0, 1'b0, 1'b0);
      settle();
      n_cmp++;
      if (got.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL errors_count: got %0d events expected %0d", got.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         n_cmp++;
         if (got[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL errors_event%0d: got %0d expected %0d", i, got[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (received_data !== 8'h1C) begin
         n_bad++;
         $display("FAIL errors_hold_data: got %h expected 1c", received_data);
      end
   endtask

   task automatic test_timeout();
      int  k = 0;
      bit  seen = 0;
      bit  early_busy = 0;
      got.delete(); exp_q.delete();
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      ps2_dat_in = 1'b1;
      repeat (H) @(negedge CLOCK_50);
      ps2_clk_in = 1'b0;
      while (!seen && k < T + 3 + FL + 50) begin
         @(negedge CLOCK_50);
         k++;
         if (k == H) ps2_clk_in = 1'b1;
         if (k == T + 2 + FL) early_busy = busy;
         if (framing_error) seen = 1;
      end
      n_cmp++;
      if (!seen || k != T + 3 + FL) begin
         n_bad++;
         $display("FAIL timeout_latency: seen %0d after %0d cycles expected %0d", seen, k, T + 3 + FL);
      end
      n_cmp++;
      if (early_busy !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_busy: before %b at %b expected 1 then 0", early_busy, busy);
      end
      send_frame(8'h29, good_par(8'h29), 1'b1, 1'b0);
      settle();
      n_cmp++;
      if (got.size() != 2 || got[0] !== 512 || got[1] !== exp_q[0]) begin
         n_bad++;
         $display("FAIL timeout_events: got %0d events last %0d expected 512 then %0d", got.size(), got.size() ? got[$] : -1, exp_q[0]);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d = 8'($urandom);
      got.delete(); exp_q.delete();
      send_bit(1'b0, 1'b0);
      send_bit(d[0], 1'b0);
      send_bit(d[1], 1'b0);
      #3 reset = 1'b1;
      #1;
      n_cmp++;
      if ({received_data, received_data_en, parity_error, framing_error, busy} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_async: got %h expected 000", {received_data, received_data_en, parity_error, framing_error, busy});
      end
      ps2_clk_in = 1'b1;
      ps2_dat_in = 1'b1;
      repeat (4) @(negedge CLOCK_50);
      reset = 1'b0;
      last_good = 0;
      settle();
      n_cmp++;
      if (got.size() != 0) begin
         n_bad++;
         $display("FAIL reset_no_strobe: got %0d events expected 0", got.size());
      end
      send_frame(d, good_par(d), 1'b1, 1'b0);
      settle();
      n_cmp++;
      if (got.size() != 1 || got[0] !== exp_q[0]) begin
         n_bad++;
         $display("FAIL reset_next_frame: got %0d events first %0d expected %0d", got.size(), got.size() ? got[0] : -1, exp_q[0]);
      end
   endtask

   task automatic test_random();
      got.delete(); exp_q.delete();
      for (int n = 0; n < 16; n++) begin
         logic [7:0] d = 8'($urandom);
         logic       p = ($urandom_range(3) != 0) ? good_par(d) : ~good_par(d);
         logic       s = ($urandom_range(4) != 0);
         send_frame(d, p, s, 1'b0);
      end
      settle();
      n_cmp++;
      if (got.size() != exp_q.size()) begin
         n_bad++;
         $display("FAIL random_count: got %0d events expected %0d", got.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         n_cmp++;
         if (got[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL random_event%0d: got %0d expected %0d", i, got[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (int'(received_data) !== last_good) begin
         n_bad++;
         $display("FAIL random_final: got %h expected %h", received_data, last_good);
      end
   endtask

   task automatic test_glitch();
      got.delete(); exp_q.delete();
      send_frame(8'h5A, good_par(8'h5A), 1'b1, 1'b1);
      settle();
      n_cmp++;
      if (got.size() != 1 || got[0] !== 32'h5A) begin
         n_bad++;
         $display("FAIL glitch_5a: got %0d events first %0d expected 1 event 90", got.size(), got.size() ? got[0] : -1);
      end
   endtask

   initial begin
      test_reset();
      test_make_code();
      test_back_to_back();
      test_errors();
      test_timeout();
      test_reset_mid_frame();
      test_random();
`ifdef PS2_RX_GLITCH_FILTER_EN
      test_glitch();
`endif
      n_cmp++;
      if (multi != 0) begin
         n_bad++;
         $display("FAIL one_strobe: got %0d multi-strobe cycles expected 0", multi);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
